// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: hazard FSM encodings, forwarding selects and
// the register-address width used by the hazard controller.
package cpu_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_BR_STALL = 2'b01,
    HZ_LD_STALL = 2'b10,
    HZ_FREEZE   = 2'b11
  } hz_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipeline: branch-operand and
// load-use hazards, branch-operand forwarding, memory-busy freeze, perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_decode_ctrl_bez,
  input  logic              ID_decode_ctrl_bnez,
  input  logic [REG_AW-1:0] ID_rD_addr,
  input  logic [REG_AW-1:0] ID_rA_addr,
  input  logic [REG_AW-1:0] ID_rB_addr,
  input  logic              ID_uses_rA,
  input  logic              ID_uses_rB,
  input  logic              ID_br_ctrl,
  input  logic              EX_reg_wr,
  input  logic              EX_is_load,
  input  logic [REG_AW-1:0] EX_rD_addr,
  input  logic              MEM_reg_wr,
  input  logic              MEM_is_load,
  input  logic [REG_AW-1:0] MEM_rD_addr,
  input  logic              WB_reg_wr,
  input  logic [REG_AW-1:0] WB_rD_addr,
  input  logic              MEM_busy,
  input  logic              cnt_clr,
  output logic              PC_stall,
  output logic              IF_ID_stall,
  output logic              IF_ID_flush,
  output logic              ID_EX_bubble,
  output logic              EX_MEM_stall,
  output logic              MEM_WB_bubble,
  output logic [1:0]        ID_br_fwd_sel,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  import cpu_pkg::*;

  hz_state_e state_q;
  hz_state_e state_d;

  logic is_br;
  logic ex_hit_rd, mem_hit_rd, wb_hit_rd;
  logic ex_hit_ra, ex_hit_rb;
  logic br_haz, ld_haz, taken;

  logic pc_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_wb_bubble;
  logic [1:0] fwd_sel;

  // r0 is hard-wired zero, so a write to it never creates a dependency.
  always_comb begin
    is_br      = ID_decode_ctrl_bez | ID_decode_ctrl_bnez;
    ex_hit_rd  = EX_reg_wr  && (EX_rD_addr  != '0) && (EX_rD_addr  == ID_rD_addr);
    mem_hit_rd = MEM_reg_wr && (MEM_rD_addr != '0) && (MEM_rD_addr == ID_rD_addr);
    wb_hit_rd  = WB_reg_wr  && (WB_rD_addr  != '0) && (WB_rD_addr  == ID_rD_addr);
    ex_hit_ra  = EX_reg_wr  && (EX_rD_addr  != '0) && ID_uses_rA && (EX_rD_addr == ID_rA_addr);
    ex_hit_rb  = EX_reg_wr  && (EX_rD_addr  != '0) && ID_uses_rB && (EX_rD_addr == ID_rB_addr);
    br_haz     = is_br && (ex_hit_rd || (mem_hit_rd && MEM_is_load));
    ld_haz     = EX_is_load && (ex_hit_ra || ex_hit_rb);
    taken      = is_br && ID_br_ctrl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A freeze leaves no memory: the state after it is purely what the
  // hazard inputs say in the first non-busy cycle.
  always_comb begin
    state_d = HZ_RUN;
    if (reset) begin
      state_d = HZ_RUN;
    end else if (MEM_busy) begin
      state_d = HZ_FREEZE;
    end else if (br_haz) begin
      state_d = HZ_BR_STALL;
    end else if (ld_haz) begin
      state_d = HZ_LD_STALL;
    end
  end

  always_comb begin
    pc_stall      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    fwd_sel       = FWD_RF;
    if (!reset) begin
      if (MEM_busy) begin
        pc_stall      = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (br_haz || ld_haz) begin
        pc_stall     = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (taken) begin
        if_id_flush = 1'b1;
      end
      if (!br_haz) begin
        if (mem_hit_rd && !MEM_is_load) begin
          fwd_sel = FWD_EXMEM;
        end else if (wb_hit_rd) begin
          fwd_sel = FWD_MEMWB;
        end
      end
    end
  end

  assign PC_stall      = pc_stall;
  assign IF_ID_stall   = pc_stall;
  assign IF_ID_flush   = if_id_flush;
  assign ID_EX_bubble  = id_ex_bubble;
  assign EX_MEM_stall  = ex_mem_stall;
  assign MEM_WB_bubble = mem_wb_bubble;
  assign ID_br_fwd_sel = fwd_sel;
  assign hz_state      = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_stall),
    .clr   (cnt_clr),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_id_flush),
    .clr   (cnt_clr),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; narrow counters make saturation reachable.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_HAZ   = 6'b110100;
  localparam logic [5:0] C_FLUSH = 6'b001000;
  localparam logic [5:0] C_FRZ   = 6'b110011;

  localparam logic [1:0] S_RUN = 2'd0, S_BR = 2'd1, S_LD = 2'd2, S_FRZ = 2'd3;
  localparam logic [1:0] F_RF = 2'd0, F_EXMEM = 2'd1, F_MEMWB = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          bez = 1'b0, bnez = 1'b0, br_ctrl = 1'b0;
  logic [AW-1:0] id_rd = '0, id_ra = '0, id_rb = '0;
  logic          uses_ra = 1'b0, uses_rb = 1'b0;
  logic          ex_wr = 1'b0, ex_ld = 1'b0, mem_wr = 1'b0, mem_ld = 1'b0, wb_wr = 1'b0;
  logic [AW-1:0] ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic          mem_busy = 1'b0, cnt_clr = 1'b0;

  logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_wb_bubble;
  logic [1:0]    fwd_sel, hz_state;
  logic [CW-1:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ID_decode_ctrl_bez  (bez),
    .ID_decode_ctrl_bnez (bnez),
    .ID_rD_addr          (id_rd),
    .ID_rA_addr          (id_ra),
    .ID_rB_addr          (id_rb),
    .ID_uses_rA          (uses_ra),
    .ID_uses_rB          (uses_rb),
    .ID_br_ctrl          (br_ctrl),
    .EX_reg_wr           (ex_wr),
    .EX_is_load          (ex_ld),
    .EX_rD_addr          (ex_rd),
    .MEM_reg_wr          (mem_wr),
    .MEM_is_load         (mem_ld),
    .MEM_rD_addr         (mem_rd),
    .WB_reg_wr           (wb_wr),
    .WB_rD_addr          (wb_rd),
    .MEM_busy            (mem_busy),
    .cnt_clr             (cnt_clr),
    .PC_stall            (pc_stall),
    .IF_ID_stall         (if_id_stall),
    .IF_ID_flush         (if_id_flush),
    .ID_EX_bubble        (id_ex_bubble),
    .EX_MEM_stall        (ex_mem_stall),
    .MEM_WB_bubble       (mem_wb_bubble),
    .ID_br_fwd_sel       (fwd_sel),
    .hz_state            (hz_state),
    .stall_cycles        (stall_cycles),
    .flush_count         (flush_count)
  );

  typedef struct {
    logic [5:0]    ctrl;
    logic [1:0]    fwd;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vec_id = 0;

  logic [CW-1:0] m_sc = '0;
  logic [CW-1:0] m_fc = '0;
  logic [1:0]    m_st = S_RUN;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %0h expected %0h", vec_id, tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic bz, input logic bnz, input logic [AW-1:0] rd, input logic tk,
                        input logic [AW-1:0] ra, input logic ua, input logic [AW-1:0] rb, input logic ub);
    bez = bz; bnez = bnz; id_rd = rd; br_ctrl = tk;
    id_ra = ra; uses_ra = ua; id_rb = rb; uses_rb = ub;
  endtask

  task automatic set_pipe(input logic exw, input logic exl, input logic [AW-1:0] exd,
                          input logic mw, input logic ml, input logic [AW-1:0] md,
                          input logic ww, input logic [AW-1:0] wd);
    ex_wr = exw; ex_ld = exl; ex_rd = exd;
    mem_wr = mw; mem_ld = ml; mem_rd = md;
    wb_wr = ww; wb_rd = wd;
  endtask

  // Inputs are already driven (just after a negedge); expected combinational
  // outputs come from the caller, registered state/counters from the model.
  task automatic step(input logic [5:0] ectrl, input logic [1:0] efwd, input logic [1:0] enext);
    exp_t e;
    exp_t g;
    logic [5:0] octrl;
    e.ctrl = ectrl; e.fwd = efwd; e.st = m_st; e.sc = m_sc; e.fc = m_fc;
    sb_q.push_back(e);
    #2;
    g = sb_q.pop_front();
    octrl = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_wb_bubble};
    chk("ctrl",  32'(octrl),        32'(g.ctrl));
    chk("fwd",   32'(fwd_sel),      32'(g.fwd));
    chk("state", 32'(hz_state),     32'(g.st));
    chk("stall", 32'(stall_cycles), 32'(g.sc));
    chk("flush", 32'(flush_count),  32'(g.fc));
    $display("vec %0d rst=%b busy=%b clr=%b ctrl=%b fwd=%b st=%0d sc=%0d fc=%0d",
             vec_id, reset, mem_busy, cnt_clr, octrl, fwd_sel, hz_state, stall_cycles, flush_count);
    if (reset) begin
      m_sc = '0; m_fc = '0; m_st = S_RUN;
    end else begin
      if (cnt_clr) begin
        m_sc = '0; m_fc = '0;
      end else begin
        if (ectrl[5] && (m_sc != '1)) m_sc = m_sc + 1'b1;
        if (ectrl[3] && (m_fc != '1)) m_fc = m_fc + 1'b1;
      end
      m_st = enext;
    end
    vec_id++;
    @(negedge clk);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_pipe(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    // reset overrides a live hazard and a live forward
    set_id(1, 0, 5, 1, 0, 0, 0, 0);
    set_pipe(1, 0, 5, 0, 0, 0, 0, 0); step(C_IDLE, F_RF, S_RUN);
    set_pipe(0, 0, 0, 1, 0, 5, 0, 0); step(C_IDLE, F_RF, S_RUN);
    reset = 1'b0;

    // bez r5 behind add r5: one stall, then forward EX/MEM and flush
    set_pipe(1, 0, 5, 0, 0, 0, 0, 0); step(C_HAZ,   F_RF,    S_BR);
    set_pipe(0, 0, 0, 1, 0, 5, 0, 0); step(C_FLUSH, F_EXMEM, S_RUN);
    idle();                           step(C_IDLE,  F_RF,    S_RUN);

    // bnez r7 behind load r7: two stalls, then forward MEM/WB
    set_id(0, 1, 7, 0, 0, 0, 0, 0);
    set_pipe(1, 1, 7, 0, 0, 0, 0, 0); step(C_HAZ,  F_RF,    S_BR);
    set_pipe(0, 0, 0, 1, 1, 7, 0, 0); step(C_HAZ,  F_RF,    S_BR);
    set_pipe(0, 0, 0, 0, 0, 0, 1, 7); step(C_IDLE, F_MEMWB, S_RUN);
    set_id(0, 1, 7, 1, 0, 0, 0, 0);   step(C_FLUSH, F_MEMWB, S_RUN);

    // MEM beats WB; r0 and non-writing producers never matter
    set_id(1, 0, 6, 0, 0, 0, 0, 0);
    set_pipe(0, 0, 0, 1, 0, 6, 1, 6); step(C_IDLE, F_EXMEM, S_RUN);
    set_id(1, 0, 0, 0, 0, 0, 0, 0);
    set_pipe(1, 0, 0, 0, 0, 0, 1, 0); step(C_IDLE, F_RF, S_RUN);
    set_id(1, 0, 5, 0, 0, 0, 0, 0);
    set_pipe(0, 0, 5, 0, 0, 0, 0, 0); step(C_IDLE, F_RF, S_RUN);

    // load-use on rA / rB
    set_id(0, 0, 0, 0, 3, 1, 0, 0);
    set_pipe(1, 1, 3, 0, 0, 0, 0, 0); step(C_HAZ,  F_RF, S_LD);
    set_pipe(0, 0, 0, 1, 1, 3, 0, 0); step(C_IDLE, F_RF, S_RUN);
    set_id(0, 0, 0, 0, 0, 1, 0, 0);
    set_pipe(1, 1, 0, 0, 0, 0, 0, 0); step(C_IDLE, F_RF, S_RUN);
    set_id(0, 0, 0, 0, 0, 0, 9, 1);
    set_pipe(1, 1, 9, 0, 0, 0, 0, 0); step(C_HAZ,  F_RF, S_LD);
    set_id(0, 0, 0, 0, 0, 0, 9, 0);   step(C_IDLE, F_RF, S_RUN);

    // branch and load-use hazards together report as branch stall
    set_id(1, 0, 4, 0, 4, 1, 0, 0);
    set_pipe(1, 1, 4, 0, 0, 0, 0, 0); step(C_HAZ,  F_RF, S_BR);
    idle();                           step(C_IDLE, F_RF, S_RUN);

    // four busy cycles over a taken-branch hazard, then normal resolution
    set_id(1, 0, 5, 1, 0, 0, 0, 0);
    set_pipe(1, 0, 5, 0, 0, 0, 0, 0);
    mem_busy = 1'b1;
    repeat (4) step(C_FRZ, F_RF, S_FRZ);
    mem_busy = 1'b0;                  step(C_HAZ,   F_RF,    S_BR);
    set_pipe(0, 0, 0, 1, 0, 5, 0, 0); step(C_FLUSH, F_EXMEM, S_RUN);

    // reset while in branch stall
    set_pipe(1, 0, 5, 0, 0, 0, 0, 0); step(C_HAZ,  F_RF, S_BR);
    reset = 1'b1;                     step(C_IDLE, F_RF, S_RUN);
    reset = 1'b0; idle();             step(C_IDLE, F_RF, S_RUN);

    // stall counter saturation, then clear beating increment
    mem_busy = 1'b1;
    repeat (17) step(C_FRZ, F_RF, S_FRZ);
    cnt_clr = 1'b1;                   step(C_FRZ,  F_RF, S_FRZ);
    cnt_clr = 1'b0; mem_busy = 1'b0;  step(C_IDLE, F_RF, S_RUN);
    step(C_IDLE, F_RF, S_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
